// File: rtl/multicycle_sequencer_if.sv
// Bundle of fetch, data-memory, decoder and datapath-control signals driven by the sequencer.
interface multicycle_sequencer_if #(
  parameter int unsigned RET_W = 32
);
  logic [31:0]      inst_addr;
  logic             imem_req;
  logic             imem_ready;
  logic [31:0]      imem_rdata;
  logic [31:0]      inst;
  logic [3:0]       alu_control;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ready;
  logic             rf_we;
  logic             wb_sel;
  logic             alu_src_imm;
  logic             halted;
  logic             err;
  logic [RET_W-1:0] instret;

  modport master (
    output inst_addr, imem_req, inst, dmem_req, dmem_we, rf_we, wb_sel, alu_src_imm,
           halted, err, instret,
    input  imem_ready, imem_rdata, alu_control, dmem_ready
  );

  modport slave (
    input  inst_addr, imem_req, inst, dmem_req, dmem_we, rf_we, wb_sel, alu_src_imm,
           halted, err, instret,
    output imem_ready, imem_rdata, alu_control, dmem_ready
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, write-back, with timeout halt.
module multicycle_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RET_W       = 32
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_sequencer_if.master  bus_io
);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [2:0] ClsR     = 3'd0;
  localparam logic [2:0] ClsI     = 3'd1;
  localparam logic [2:0] ClsLoad  = 3'd2;
  localparam logic [2:0] ClsStore = 3'd3;
  localparam logic [2:0] ClsLui   = 3'd4;

  localparam int unsigned CntW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       cls_q, cls_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [RET_W-1:0] instret_q, instret_d;
  logic             err_q, err_d;

  logic             dec_legal;
  logic [2:0]       dec_cls;

  always_comb begin
    dec_legal = 1'b1;
    dec_cls   = ClsR;
    case (inst_q[6:0])
      7'h33:   dec_cls = ClsR;
      7'h13:   dec_cls = ClsI;
      7'h03:   dec_cls = ClsLoad;
      7'h23:   dec_cls = ClsStore;
      7'h37:   dec_cls = ClsLui;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    cnt_d     = cnt_q;
    instret_d = instret_q;
    err_d     = err_q;
    case (state_q)
      StFetch: begin
        if (bus_io.imem_ready) begin
          inst_d  = bus_io.imem_rdata;
          cnt_d   = '0;
          state_d = StDecode;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDecode: begin
        cnt_d = '0;
        if (!dec_legal || (bus_io.alu_control == 4'b1111)) begin
          state_d = StHalt;
        end else begin
          cls_d   = dec_cls;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = ((cls_q == ClsLoad) || (cls_q == ClsStore)) ? StMem : StWb;
      end
      StMem: begin
        if (bus_io.dmem_ready) begin
          cnt_d = '0;
          if (cls_q == ClsLoad) begin
            state_d = StWb;
          end else begin
            pc_d      = pc_q + 32'd4;
            instret_d = instret_q + 1'b1;
            state_d   = StFetch;
          end
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb: begin
        pc_d      = pc_q + 32'd4;
        instret_d = instret_q + 1'b1;
        state_d   = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      cls_q     <= ClsR;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      cnt_q     <= '0;
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
      err_q     <= err_d;
    end
  end

  // Enables are gated by rst so nothing reaches memory or the register file while in reset.
  always_comb begin
    bus_io.inst_addr   = pc_q;
    bus_io.inst        = inst_q;
    bus_io.instret     = instret_q;
    bus_io.err         = err_q;
    bus_io.halted      = (state_q == StHalt);
    bus_io.imem_req    = !rst && (state_q == StFetch);
    bus_io.dmem_req    = !rst && (state_q == StMem);
    bus_io.dmem_we     = !rst && (state_q == StMem) && (cls_q == ClsStore);
    bus_io.rf_we       = !rst && (state_q == StWb) && (inst_q[11:7] != 5'd0);
    bus_io.wb_sel      = !rst && (state_q == StWb) && (cls_q == ClsLoad);
    bus_io.alu_src_imm = !rst && (cls_q != ClsR) &&
                         ((state_q == StExec) || (state_q == StMem) || (state_q == StWb));
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized scoreboard bench for multicycle_sequencer with an instruction-level reference model.
module tb_multicycle_sequencer;

  localparam logic [31:0] RstPc = 32'hFFFF_FFF0;
  localparam int          To    = 16;

  typedef struct {
    logic [31:0] instr;
    int          iw;
    int          dw;
    bit          ill;
  } plan_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ret;
    logic [31:0] inst;
    bit          halt;
    bit          err;
    int          cyc;
    int          ireq;
    int          rfw;
    int          wbs;
    int          rdc;
    int          wrc;
    int          imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.RET_W(32)) bus ();

  multicycle_sequencer #(
    .RESET_PC   (RstPc),
    .MEM_TIMEOUT(To),
    .RET_W      (32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          halt_bad = 0;
  int          halt_cyc = 0;
  plan_t       plan_q[$];
  exp_t        sb_q[$];
  logic [31:0] m_pc, m_ret, m_inst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: whole-instruction outcome from opcode, rd and the planned wait counts.
  task automatic push(input logic [31:0] ins, input int iw, input int dw, input bit ill);
    exp_t  e;
    plan_t p;
    logic [6:0] op;
    bit ld, st, rr, legal;
    p = '{instr: ins, iw: iw, dw: dw, ill: ill};
    plan_q.push_back(p);
    op = ins[6:0];
    ld = (op == 7'h03);
    st = (op == 7'h23);
    rr = (op == 7'h33);
    legal = ld || st || rr || (op == 7'h13) || (op == 7'h37);
    e = '{pc: 0, ret: 0, inst: 0, halt: 0, err: 0, cyc: 0, ireq: 0, rfw: 0, wbs: 0,
          rdc: 0, wrc: 0, imm: 0};
    if (iw >= To) begin
      e.halt = 1; e.err = 1; e.cyc = To; e.ireq = To;
    end else begin
      m_inst = ins;
      e.ireq = iw + 1;
      if (!legal || ill) begin
        e.halt = 1; e.cyc = iw + 2;
      end else if ((ld || st) && dw >= To) begin
        e.halt = 1; e.err = 1; e.cyc = iw + 3 + To; e.imm = 1 + To;
        if (ld) e.rdc = To; else e.wrc = To;
      end else begin
        m_pc  = m_pc + 32'd4;
        m_ret = m_ret + 32'd1;
        e.rfw = (!st && ins[11:7] != 5'd0) ? 1 : 0;
        e.wbs = ld ? 1 : 0;
        e.rdc = ld ? dw + 1 : 0;
        e.wrc = st ? dw + 1 : 0;
        e.cyc = iw + (ld ? 5 + dw : (st ? 4 + dw : 4));
        e.imm = rr ? 0 : (ld ? 3 + dw : (st ? 2 + dw : 2));
      end
    end
    e.pc = m_pc; e.ret = m_ret; e.inst = m_inst;
    sb_q.push_back(e);
  endtask

  // Memory/decoder responder: follows the plan queue, randomizes ready while not requested.
  initial begin
    plan_t cur;
    bit act = 0, need_new = 1;
    int icnt = 0, dcnt = 0;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.dmem_ready = 1'b0; bus.alu_control = '0;
    cur = '{instr: 0, iw: 0, dw: 0, ill: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 0; need_new = 1;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        continue;
      end
      if (bus.imem_req) begin
        if (need_new && plan_q.size() > 0) begin
          cur = plan_q.pop_front(); act = 1; need_new = 0; icnt = 0; dcnt = 0;
        end
        if (act && !need_new && icnt == cur.iw) begin
          bus.imem_ready = 1'b1; bus.imem_rdata = cur.instr; need_new = 1;
        end else begin
          bus.imem_ready = 1'b0; bus.imem_rdata = $urandom; icnt++;
        end
      end else begin
        bus.imem_ready = 1'($urandom_range(0, 1));
      end
      if (bus.dmem_req && act) begin
        if (dcnt == cur.dw) bus.dmem_ready = 1'b1;
        else begin bus.dmem_ready = 1'b0; dcnt++; end
      end else begin
        bus.dmem_ready = 1'($urandom_range(0, 1));
      end
      bus.alu_control = (act && cur.ill) ? 4'b1111 : 4'($urandom_range(0, 14));
    end
  end

  // Monitor: each retirement or halt pops one expected record and compares the observed window.
  initial begin
    int cyc = 0, ireq = 0, rfw = 0, wbs = 0, rdc = 0, wrc = 0, imm = 0;
    logic [31:0] last_ret = 0, halt_pc = 0;
    bit last_h = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; ireq = 0; rfw = 0; wbs = 0; rdc = 0; wrc = 0; imm = 0;
        last_ret = 0; last_h = 0;
        continue;
      end
      if (bus.instret !== last_ret || (bus.halted && !last_h)) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_event: instret %0h halted %0b with empty scoreboard",
                   bus.instret, bus.halted);
        end else begin
          e = sb_q.pop_front();
          check("halted", 32'(bus.halted), 32'(e.halt));
          check("err", 32'(bus.err), 32'(e.err));
          check("pc", bus.inst_addr, e.pc);
          check("instret", bus.instret, e.ret);
          check("inst", bus.inst, e.inst);
          check("latency", cyc, e.cyc);
          check("imem_req_cycles", ireq, e.ireq);
          check("rf_we_cycles", rfw, e.rfw);
          check("wb_sel_cycles", wbs, e.wbs);
          check("load_cycles", rdc, e.rdc);
          check("store_cycles", wrc, e.wrc);
          check("alu_src_imm_cycles", imm, e.imm);
        end
        cyc = 0; ireq = 0; rfw = 0; wbs = 0; rdc = 0; wrc = 0; imm = 0;
        halt_pc = bus.inst_addr;
      end
      last_ret = bus.instret;
      last_h   = bus.halted;
      if (bus.halted) begin
        halt_cyc++;
        if (bus.imem_req || bus.dmem_req || bus.dmem_we || bus.rf_we || bus.wb_sel ||
            bus.alu_src_imm || bus.inst_addr !== halt_pc) halt_bad++;
      end else begin
        cyc++;
        ireq += int'(bus.imem_req);
        rfw  += int'(bus.rf_we);
        wbs  += int'(bus.wb_sel);
        rdc  += int'(bus.dmem_req && !bus.dmem_we);
        wrc  += int'(bus.dmem_req && bus.dmem_we);
        imm  += int'(bus.alu_src_imm);
      end
    end
  end

  task automatic reset_begin();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    plan_q.delete(); sb_q.delete();
    m_pc = RstPc; m_ret = 0; m_inst = 0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    check({name, "_drained"}, sb_q.size(), 0);
  endtask

  task automatic check_halt(input string name, input bit exp_err);
    halt_bad = 0; halt_cyc = 0;
    repeat (6) @(negedge clk);
    check({name, "_halt_cycles"}, halt_cyc, 6);
    check({name, "_halt_quiet"}, halt_bad, 0);
    check({name, "_err"}, 32'(bus.err), 32'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [6:0] ops[5];
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h37;
    m_pc = RstPc; m_ret = 0; m_inst = 0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_enables", {26'd0, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.rf_we,
                          bus.wb_sel, bus.alu_src_imm}, 32'd0);
    check("rst_status", {30'd0, bus.halted, bus.err}, 32'd0);
    check("rst_pc", bus.inst_addr, RstPc);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_instret", bus.instret, 32'd0);

    // Directed set wraps the PC from FFFF_FFF0 to 0 on the fourth retirement.
    push(32'h0050_0093, 0, 0, 0);
    push(32'h0000_A103, 0, 3, 0);
    push(32'h0020_A223, 0, 0, 0);
    push(32'h0010_0013, 0, 0, 0);
    push(32'h1234_50B7, 1, 0, 0);
    push(32'h0020_81B3, 2, 0, 0);
    push(32'h0050_0093, To - 1, 0, 0);
    push(32'h0000_A103, 0, To - 1, 0);
    for (int i = 0; i < 30; i++) begin
      logic [31:0] r;
      r = $urandom;
      push({r[31:7], ops[$urandom_range(0, 4)]}, $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    push(32'h0000_0000, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
    wait_drain("run");
    check_halt("illegal_op", 1'b0);

    // Reset while a load is stuck waiting on data memory.
    reset_begin();
    plan_q.push_back('{instr: 32'h0000_A103, iw: 0, dw: 100, ill: 0});
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 100 && n < 3; k++) begin
      @(negedge clk);
      if (bus.dmem_req) n++;
    end
    check("mem_wait_reached", n, 3);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_gates_dmem", {30'd0, bus.dmem_req, bus.imem_req}, 32'd0);
    @(posedge clk); #1;
    plan_q.delete(); sb_q.delete();
    m_pc = RstPc; m_ret = 0; m_inst = 0;
    push(32'h0050_0093, 0, 0, 1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_fetch", {30'd0, bus.imem_req, bus.dmem_req}, 32'd2);
    check("post_rst_instret", bus.instret, 32'd0);
    check("post_rst_pc", bus.inst_addr, RstPc);
    wait_drain("alu_illegal");
    check_halt("alu_illegal", 1'b0);

    reset_begin();
    push(32'h0050_0093, 100, 0, 0);
    rst = 1'b0;
    wait_drain("imem_timeout");
    check_halt("imem_timeout", 1'b1);

    reset_begin();
    push(32'h0020_A223, 0, 100, 0);
    rst = 1'b0;
    wait_drain("dmem_timeout");
    check_halt("dmem_timeout", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the single-issue RV32I datapath: instruction fetch, decode, execute, memory access and register write-back.
- Owns the PC and the instruction register. Drives the instruction address into the decoder and the memory/register-file enables into the datapath.
- Handshakes with instruction and data memories via req/ready. Halts on illegal opcodes and on memory timeouts.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 16, max cycles a memory request may wait for ready before error halt (>=2).
- RET_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- inst_addr  out  32  current PC, to instruction memory and decoder
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  instruction data valid this cycle
- imem_rdata  in  32  fetched instruction
- inst  out  32  latched instruction register, to decoder
- alu_control  in  4  decoder ALU code; 4'b1111 = illegal
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req
- dmem_ready  in  1  data access complete
- rf_we  out  1  register-file write strobe, one cycle
- wb_sel  out  1  0 = ALU result, 1 = load data
- alu_src_imm  out  1  1 = ALU operand B is immSmall
- halted  out  1  sticky halt
- err  out  1  sticky: halt caused by timeout (0 = illegal opcode)
- instret  out  RET_W  retired instruction count

Behaviour:
- Reset, at the clock edge with rst=1:
  - State goes to FETCH; inst_addr=RESET_PC; inst=0; instret=0; halted=0; err=0; wait counter=0.
  - While rst=1, imem_req, dmem_req, dmem_we, rf_we, wb_sel and alu_src_imm are forced to 0.
  - Reset mid-operation abandons any outstanding request; no write-back occurs.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are Moore, decoded from state and latched instruction class.
- FETCH:
  - imem_req=1.
  - On imem_ready=1: latch imem_rdata into inst, go to DECODE.
  - Otherwise increment wait counter. If the counter reaches MEM_TIMEOUT-1 without ready: go to HALT, err=1.
- DECODE (1 cycle): classify inst[6:0].
  - 0x33 = R; 0x13 = I; 0x03 = LOAD; 0x23 = STORE; 0x37 = LUI; anything else = illegal.
  - Illegal opcode, or alu_control==4'b1111: go to HALT, err=0.
  - Otherwise go to EXEC. Wait counter clears.
- EXEC (1 cycle):
  - alu_src_imm=1 for I, LOAD, STORE, LUI; 0 for R.
  - Next state: MEM for LOAD/STORE, else WB.
- MEM:
  - dmem_req=1; dmem_we=1 only for STORE. alu_src_imm is held.
  - On dmem_ready=1: LOAD goes to WB. STORE retires: PC+=4, instret+=1, go to FETCH.
  - Timeout: same rule as FETCH (HALT, err=1).
- WB (1 cycle):
  - rf_we=1 unless rd=inst[11:7]=0 (x0 writes suppressed).
  - wb_sel=1 for LOAD, else 0.
  - PC+=4, instret+=1, go to FETCH.
- HALT: terminal until rst. All req/enables are 0; halted=1; PC and instret frozen.
- Arithmetic and wrap rules:
  - PC is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
  - instret wraps modulo 2^RET_W.
- Ready handling:
  - imem_ready/dmem_ready are ignored in any state not asserting the matching req.
  - Ready in the same cycle as req completes the access (zero-wait).
- Latency with zero-wait memory, request to next FETCH:
  - R/I/LUI: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - Each wait cycle adds 1.

Test Plan:
- Reset, then imem_ready=1 always, imem_rdata=addi x1,x0,5 (0x00500093) -> DECODE/EXEC/WB; rf_we=1 for exactly 1 cycle in WB with alu_src_imm=1; inst_addr 0->4; instret=1 after 4 cycles.
- Load lw x2,0(x1) (0x0000A103), dmem_ready held 0 for 3 cycles -> dmem_req=1, dmem_we=0 for 4 cycles; WB wb_sel=1, rf_we=1; retire at cycle 8.
- Store sw x2,4(x1) (0x0020A223), zero-wait -> dmem_req=1 with dmem_we=1 for 1 cycle; rf_we never asserts; PC+=4 in 4 cycles.
- Instruction 0x00000000 -> HALT after DECODE; halted=1, err=0; no further imem_req; PC unchanged.
- imem_ready stuck 0, MEM_TIMEOUT=16 -> imem_req high for exactly 16 cycles, then halted=1, err=1.
- Edge cases:
  - RESET_PC=32'hFFFF_FFFC executing one addi -> inst_addr becomes 0.
  - addi x0,x0,1 -> rf_we stays 0, instret still increments.
  - rst asserted during MEM wait -> next cycle FETCH, dmem_req=0, instret=0.
